pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-address controller for the 8-bit core's program_counter register.
//  Drives the PC input every cycle from the current PC and decoded control:
//  increment, stall, jump, conditional branch, halt/resume, and optional call/return.
//  Sits between decode/control and the PC register.
//  Issues a one-cycle fetch flush after every redirect.
// PARAMETERS
//  DATA_WIDTH    8     PC/address width in bits
//  RESET_VECTOR  0     first fetch address, loaded in the BOOT cycle after reset
//  STACK_DEPTH   4     return-stack entries (used only with PC_CALL_STACK_EN); >=1
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  pc_cur     in   DATA_WIDTH  current PC (program_counter pc_out)
//  pc_next    out  DATA_WIDTH  next PC (program_counter pc_in); combinational
//  stall      in   1           hold PC this cycle
//  jump       in   1           unconditional redirect to target
//  branch     in   1           conditional redirect to target
//  br_cond    in   1           branch condition; taken when branch & br_cond
//  target     in   DATA_WIDTH  jump/branch/call destination
//  call       in   1           push return address, redirect (stack build only)
//  ret        in   1           pop return address, redirect (stack build only)
//  halt       in   1           enter HALT
//  resume     in   1           leave HALT
//  halted     out  1           registered; 1 while in HALT
//  flush      out  1           registered; 1 for exactly one cycle after a redirect
//  stack_err  out  1           registered, sticky; overflow/underflow seen
// BEHAVIOUR
//  - Reset (async): state=BOOT, halted=0, flush=0, stack_err=0, sp=0.
//    Asserting rst mid-operation discards all pending state and stack contents.
//  - FSM states: BOOT, RUN, HALT.
//  - BOOT: pc_next=RESET_VECTOR; all inputs ignored; next state is RUN.
//  - RUN: pc_next is selected by this priority (first match wins):
//    1. stall: pc_next=pc_cur; nothing else acts; no flush.
//    2. halt: pc_next=pc_cur; next state is HALT; halted=1 from the next cycle.
//    3. ret: pc_next=stack top; pop.
//    4. call: push pc_cur+1; pc_next=target.
//    5. jump: pc_next=target.
//    6. branch & br_cond: pc_next=target.
//    7. otherwise: pc_next=pc_cur+1.
//  - Redirects (3-6) set flush=1 on the following cycle.
//  - A not-taken branch is a plain increment.
//  - HALT: pc_next=pc_cur; resume moves to RUN next cycle.
//    pc_next still equals pc_cur in the resume cycle.
//    halt and resume asserted together: stay in HALT.
//  - Arithmetic: pc_cur+1 is modulo 2^DATA_WIDTH (all-ones wraps to 0).
//    The pushed return address wraps the same way.
//  - Latency: pc_next is combinational; the PC register updates at the next edge.
//    flush and halted lag their cause by one cycle.
//  - Stack boundaries:
//    - call when sp==STACK_DEPTH: no push; pc_next=pc_cur+1; stack_err<=1.
//    - ret when sp==0: no pop; pc_next=pc_cur+1; stack_err<=1.
//    - Neither case asserts flush.
//    - stack_err clears only on rst.
// CONFIGURATION
//  PC_CALL_STACK_EN defined:
//   - LIFO of STACK_DEPTH x DATA_WIDTH plus pointer sp (0..STACK_DEPTH).
//   - call/ret behave as above.
//  PC_CALL_STACK_EN undefined:
//   - No stack storage; call and ret are ignored (treated as 0).
//   - stack_err is tied to 0; all other behaviour is unchanged.
// TESTING
//  1. rst pulse, RESET_VECTOR=8'h10, no controls -> BOOT pc_next=10; then 11, 12, 13 each cycle; flush=0.
//  2. pc_cur=FF, no controls -> pc_next=00; stall=1 at pc_cur=20 -> pc_next=20, flush=0.
//  3. branch=1, br_cond=0, target=40 at pc_cur=05 -> pc_next=06.
//     Then branch=1, br_cond=1 -> pc_next=40; flush=1 on the next cycle only.
//     Then jump=1 and branch=1 together -> jump target is used.
//  4. halt at pc_cur=30 -> pc_next=30 and halted=1 until resume.
//     halt+resume together -> stays in HALT; resume alone -> RUN, then pc_next=31.
//  5. (PC_CALL_STACK_EN, STACK_DEPTH=2):
//     - call target=80 at pc_cur=10 -> pc_next=80, 11 pushed.
//     - call at 80 -> push 81; third call -> pc_next=pc_cur+1, stack_err=1.
//     - ret, ret -> 81, 11; third ret -> stack_err stays 1, pc_next=pc_cur+1.
//  6. Assert rst during HALT with sp=2 -> halted=0, sp=0, stack_err=0 immediately.
//     After release, BOOT pc_next=RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection (stall/halt/ret/call/jump/branch/increment) with a one-cycle flush after redirects
// Optional return stack enabled by `define PC_CALL_STACK_EN; without it call/ret are ignored and stack_err is 0.
// Ports: clk, rst (async, active-high); pc_cur -> pc_next (combinational);
//        stall, jump, branch, br_cond, target, call, ret, halt, resume controls;
//        halted, flush, stack_err registered status.
module pc_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_cur,
  output logic [DATA_WIDTH-1:0] pc_next,
  input  logic                  stall,
  input  logic                  jump,
  input  logic                  branch,
  input  logic                  br_cond,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  halt,
  input  logic                  resume,
  output logic                  halted,
  output logic                  flush,
  output logic                  stack_err
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] pc_inc, top;
  logic redirect, push, pop, err_set, empty, full, call_en, ret_en;
  assign pc_inc = pc_cur + 1'b1;
  always_comb begin
    state_n = state;
    pc_next = pc_inc;
    redirect = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    err_set = 1'b0;
    case (state)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_n = RUN;
      end
      HALT: begin
        pc_next = pc_cur;
        state_n = (resume && !halt) ? RUN : HALT;
      end
      default: begin
        if (stall) pc_next = pc_cur;
        else if (halt) begin
          pc_next = pc_cur;
          state_n = HALT;
        end else if (ret_en) begin
          pop = !empty;
          err_set = empty;
          redirect = !empty;
          pc_next = empty ? pc_inc : top;
        end else if (call_en) begin
          push = !full;
          err_set = full;
          redirect = !full;
          pc_next = full ? pc_inc : target;
        end else if (jump || (branch && br_cond)) begin
          redirect = 1'b1;
          pc_next = target;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      flush <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= state_n;
      flush <= redirect;
      halted <= state_n == HALT;
    end
  end
`ifdef PC_CALL_STACK_EN
  localparam int SW = $clog2(STACK_DEPTH + 1);
  logic [SW-1:0] sp;
  logic [DATA_WIDTH-1:0] stack [2**SW];
  assign call_en = call;
  assign ret_en = ret;
  assign empty = sp == '0;
  assign full = sp == SW'(STACK_DEPTH);
  assign top = stack[sp - 1'b1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      stack_err <= 1'b0;
    end else begin
      sp <= push ? sp + 1'b1 : pop ? sp - 1'b1 : sp;
      stack_err <= stack_err | err_set;
    end
  end
  always_ff @(posedge clk) begin
    if (push) stack[sp] <= pc_inc;
  end
`else
  logic unused_stack;
  assign call_en = 1'b0;
  assign ret_en = 1'b0;
  assign empty = 1'b1;
  assign full = 1'b1;
  assign top = '0;
  assign stack_err = 1'b0;
  assign unused_stack = ^{call, ret, push, pop, err_set, STACK_DEPTH};
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (stack cases active when PC_CALL_STACK_EN is defined)
module tb_pc_sequencer;
  localparam logic [6:0] ST = 7'b1000000, HA = 7'b0100000, RT = 7'b0010000, CL = 7'b0001000,
                         JP = 7'b0000100, BR = 7'b0000010, BC = 7'b0000001;
`ifdef PC_CALL_STACK_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] pc_cur = '0, target = '0, pc_next;
  logic stall = 0, jump = 0, branch = 0, br_cond = 0, call = 0, ret = 0, halt = 0, resume = 0;
  logic halted, flush, stack_err;
  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_q[$];
  logic [2:0] reg_q[$];
  pc_sequencer #(.DATA_WIDTH(8), .RESET_VECTOR(8'h10), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .stall(stall), .jump(jump),
    .branch(branch), .br_cond(br_cond), .target(target), .call(call), .ret(ret), .halt(halt),
    .resume(resume), .halted(halted), .flush(flush), .stack_err(stack_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic drive(input logic [7:0] pc, input logic [7:0] tgt, input logic [6:0] ctl,
                       input logic res, input logic [7:0] exp_pc, input logic fl,
                       input logic ha, input logic er);
    logic [2:0] r;
    pc_cur = pc;
    target = tgt;
    {stall, halt, ret, call, jump, branch, br_cond} = ctl;
    resume = res;
    exp_q.push_back(exp_pc);
    reg_q.push_back({fl, ha, er});
    #1 check("pc_next", pc_next, exp_q.pop_front());
    @(posedge clk);
    #1 r = reg_q.pop_front();
    check("flush", {7'd0, flush}, {7'd0, r[2]});
    check("halted", {7'd0, halted}, {7'd0, r[1]});
    check("stack_err", {7'd0, stack_err}, {7'd0, r[0]});
    @(negedge clk);
  endtask
  initial begin
    #100000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 check("rst_pc", pc_next, 8'h10);
    check("rst_halted", {7'd0, halted}, 8'd0);
    check("rst_flush", {7'd0, flush}, 8'd0);
    check("rst_err", {7'd0, stack_err}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h00, 8'h00, 7'd0, 0, 8'h10, 0, 0, 0);
    drive(8'h10, 8'h00, 7'd0, 0, 8'h11, 0, 0, 0);
    drive(8'h11, 8'h00, 7'd0, 0, 8'h12, 0, 0, 0);
    drive(8'h12, 8'h00, 7'd0, 0, 8'h13, 0, 0, 0);
    drive(8'hFF, 8'h00, 7'd0, 0, 8'h00, 0, 0, 0);
    drive(8'h20, 8'h70, ST | JP, 0, 8'h20, 0, 0, 0);
    drive(8'h05, 8'h40, BR, 0, 8'h06, 0, 0, 0);
    drive(8'h06, 8'h40, BR | BC, 0, 8'h40, 1, 0, 0);
    drive(8'h40, 8'h40, 7'd0, 0, 8'h41, 0, 0, 0);
    drive(8'h41, 8'h55, JP | BR, 0, 8'h55, 1, 0, 0);
    drive(8'h55, 8'h00, 7'd0, 0, 8'h56, 0, 0, 0);
    drive(8'h30, 8'h77, HA | JP, 0, 8'h30, 0, 1, 0);
    drive(8'h30, 8'h77, JP, 0, 8'h30, 0, 1, 0);
    drive(8'h30, 8'h00, HA, 1, 8'h30, 0, 1, 0);
    drive(8'h30, 8'h00, 7'd0, 1, 8'h30, 0, 0, 0);
    drive(8'h30, 8'h00, 7'd0, 0, 8'h31, 0, 0, 0);
`ifdef PC_CALL_STACK_EN
    drive(8'h10, 8'h80, CL, 0, 8'h80, 1, 0, 0);
    drive(8'h80, 8'h80, CL, 0, 8'h80, 1, 0, 0);
    drive(8'h80, 8'h80, CL, 0, 8'h81, 0, 0, 1);
    drive(8'h81, 8'h00, RT | CL, 0, 8'h81, 1, 0, 1);
    drive(8'h81, 8'h00, RT, 0, 8'h11, 1, 0, 1);
    drive(8'h11, 8'h00, RT, 0, 8'h12, 0, 0, 1);
`else
    drive(8'h10, 8'h80, CL, 0, 8'h11, 0, 0, 0);
    drive(8'h11, 8'h80, RT, 0, 8'h12, 0, 0, 0);
    drive(8'hFF, 8'h80, CL | RT, 0, 8'h00, 0, 0, 0);
`endif
    drive(8'h20, 8'h90, CL, 0, SE ? 8'h90 : 8'h21, SE, 0, SE);
    drive(8'h90, 8'h90, CL, 0, SE ? 8'h90 : 8'h91, SE, 0, SE);
    drive(8'h90, 8'h00, HA, 0, 8'h90, 0, 1, SE);
    rst = 1'b1;
    #1 check("mid_rst_halted", {7'd0, halted}, 8'd0);
    check("mid_rst_err", {7'd0, stack_err}, 8'd0);
    check("mid_rst_flush", {7'd0, flush}, 8'd0);
    check("mid_rst_pc", pc_next, 8'h10);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h00, 8'h00, 7'd0, 0, 8'h10, 0, 0, 0);
    drive(8'h10, 8'h00, RT, 0, 8'h11, 0, 0, SE);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
